// File: rtl/next_pc_unit.sv
// Next-PC generator: BTB-based fetch prediction with 2-bit counters,
// redirect on jump/mispredict, and saturating branch statistics.
module next_pc_unit #(
   parameter int IDX_W = 3,
   parameter int CNT_W = 32
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             start_i,
   input  logic [31:0]      pc_i,
   output logic [31:0]      pc_next_o,
   output logic             pred_taken_o,
   input  logic             jump_valid_i,
   input  logic [31:0]      jump_target_i,
   input  logic             br_valid_i,
   input  logic [31:0]      br_pc_i,
   input  logic             br_taken_i,
   input  logic [31:0]      br_target_i,
   input  logic [31:0]      br_pred_pc_i,
   output logic             flush_o,
   output logic             mispredict_o,
   output logic [CNT_W-1:0] br_count_o,
   output logic [CNT_W-1:0] miss_count_o
);
   localparam int ENTRIES = 2 ** IDX_W;
   localparam int TAG_W   = 32 - IDX_W - 2;

   logic             r_valid  [ENTRIES];
   logic [TAG_W-1:0] r_tag    [ENTRIES];
   logic [31:0]      r_target [ENTRIES];
   logic [1:0]       r_cnt    [ENTRIES];
   logic [CNT_W-1:0] r_br_count;
   logic [CNT_W-1:0] r_miss_count;

   logic [IDX_W-1:0] w_idx;
   logic [IDX_W-1:0] w_uidx;
   logic [TAG_W-1:0] w_tag;
   logic [TAG_W-1:0] w_utag;
   logic             w_hit;
   logic             w_uhit;
   logic             w_pred_taken;
   logic [31:0]      w_pred_pc;
   logic [31:0]      w_correct_pc;
   logic             w_mispredict;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
      return (en && (v != '1)) ? v + {{(CNT_W-1){1'b0}}, 1'b1} : v;
   endfunction

   function automatic logic [1:0] cnt_up(input logic [1:0] c);
      return (c == 2'b11) ? c : c + 2'b01;
   endfunction

   function automatic logic [1:0] cnt_dn(input logic [1:0] c);
      return (c == 2'b00) ? c : c - 2'b01;
   endfunction

   // Fetch-side lookup reads pre-edge BTB contents.
   assign w_idx        = pc_i[IDX_W+1:2];
   assign w_tag        = pc_i[31:IDX_W+2];
   assign w_hit        = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
   assign w_pred_taken = w_hit && r_cnt[w_idx][1];
   assign w_pred_pc    = w_pred_taken ? r_target[w_idx] : pc_i + 32'd4;

   // Resolve-side: compare the architecturally correct successor with what was fetched.
   assign w_uidx       = br_pc_i[IDX_W+1:2];
   assign w_utag       = br_pc_i[31:IDX_W+2];
   assign w_uhit       = r_valid[w_uidx] && (r_tag[w_uidx] == w_utag);
   assign w_correct_pc = br_taken_i ? br_target_i : br_pc_i + 32'd4;
   assign w_mispredict = br_valid_i && (w_correct_pc != br_pred_pc_i);

   assign pc_next_o    = w_mispredict ? w_correct_pc :
                         jump_valid_i ? jump_target_i : w_pred_pc;
   assign pred_taken_o = w_pred_taken;
   assign flush_o      = w_mispredict || jump_valid_i;
   assign mispredict_o = w_mispredict;
   assign br_count_o   = r_br_count;
   assign miss_count_o = r_miss_count;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         for (int i = 0; i < ENTRIES; i++) begin
            r_valid[i]  <= 1'b0;
            r_tag[i]    <= '0;
            r_target[i] <= '0;
            r_cnt[i]    <= 2'b01;
         end
         r_br_count   <= '0;
         r_miss_count <= '0;
      end else if (start_i) begin
         r_br_count   <= sat_inc(r_br_count, br_valid_i);
         r_miss_count <= sat_inc(r_miss_count, w_mispredict);
         if (br_valid_i) begin
            if (w_uhit) begin
               r_cnt[w_uidx] <= br_taken_i ? cnt_up(r_cnt[w_uidx]) : cnt_dn(r_cnt[w_uidx]);
               if (br_taken_i) begin
                  r_target[w_uidx] <= br_target_i;
               end
            end else if (br_taken_i) begin
               // Allocation evicts whatever aliased into this slot.
               r_valid[w_uidx]  <= 1'b1;
               r_tag[w_uidx]    <= w_utag;
               r_target[w_uidx] <= br_target_i;
               r_cnt[w_uidx]    <= 2'b10;
            end
         end
      end
   end
endmodule

// File: tb/tb_next_pc_unit.sv
// Self-checking bench for next_pc_unit: abstract BTB model plus directed vectors.
module tb_next_pc_unit;
   localparam int IDX_W = 3;
   localparam int CNT_W = 32;
   localparam int ENT   = 8;

   logic             clk_i = 1'b0;
   logic             rst_n_i = 1'b0;
   logic             start_i = 1'b1;
   logic [31:0]      pc_i = '0;
   logic [31:0]      pc_next_o;
   logic             pred_taken_o;
   logic             jump_valid_i = 1'b0;
   logic [31:0]      jump_target_i = '0;
   logic             br_valid_i = 1'b0;
   logic [31:0]      br_pc_i = '0;
   logic             br_taken_i = 1'b0;
   logic [31:0]      br_target_i = '0;
   logic [31:0]      br_pred_pc_i = '0;
   logic             flush_o;
   logic             mispredict_o;
   logic [CNT_W-1:0] br_count_o;
   logic [CNT_W-1:0] miss_count_o;

   int total = 0;
   int bad   = 0;

   next_pc_unit #(.IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
      .clk_i(clk_i), .rst_n_i(rst_n_i), .start_i(start_i), .pc_i(pc_i),
      .pc_next_o(pc_next_o), .pred_taken_o(pred_taken_o),
      .jump_valid_i(jump_valid_i), .jump_target_i(jump_target_i),
      .br_valid_i(br_valid_i), .br_pc_i(br_pc_i), .br_taken_i(br_taken_i),
      .br_target_i(br_target_i), .br_pred_pc_i(br_pred_pc_i),
      .flush_o(flush_o), .mispredict_o(mispredict_o),
      .br_count_o(br_count_o), .miss_count_o(miss_count_o)
   );

   always #5 clk_i = ~clk_i;

   // Abstract model: BTB as table of (valid, tag, target, strength 0..3).
   bit          m_valid [ENT];
   logic [31:0] m_tag   [ENT];
   logic [31:0] m_tgt   [ENT];
   int          m_cnt   [ENT];
   longint      m_br;
   longint      m_miss;
   localparam longint MAXC = (64'd1 << CNT_W) - 1;

   function automatic int slot(input logic [31:0] pc);
      return int'((pc / 32'd4) % ENT);
   endfunction

   function automatic logic [31:0] tagof(input logic [31:0] pc);
      return pc / (32'd4 * ENT);
   endfunction

   function automatic logic [31:0] correct_pc();
      return br_taken_i ? br_target_i : br_pc_i + 32'd4;
   endfunction

   function automatic bit exp_mp();
      return br_valid_i && (correct_pc() != br_pred_pc_i);
   endfunction

   function automatic bit exp_pt();
      int s = slot(pc_i);
      return m_valid[s] && (m_tag[s] == tagof(pc_i)) && (m_cnt[s] >= 2);
   endfunction

   function automatic logic [31:0] exp_next();
      if (exp_mp()) return correct_pc();
      if (jump_valid_i) return jump_target_i;
      if (exp_pt()) return m_tgt[slot(pc_i)];
      return pc_i + 32'd4;
   endfunction

   always @(posedge clk_i or negedge rst_n_i) begin : model
      int s;
      if (!rst_n_i) begin
         for (int i = 0; i < ENT; i++) begin
            m_valid[i] <= 1'b0; m_tag[i] <= '0; m_tgt[i] <= '0; m_cnt[i] <= 1;
         end
         m_br <= 0; m_miss <= 0;
      end else if (start_i) begin
         if (br_valid_i && m_br < MAXC) m_br <= m_br + 1;
         if (exp_mp() && m_miss < MAXC) m_miss <= m_miss + 1;
         if (br_valid_i) begin
            s = slot(br_pc_i);
            if (m_valid[s] && m_tag[s] == tagof(br_pc_i)) begin
               if (br_taken_i) begin
                  m_cnt[s] <= (m_cnt[s] < 3) ? m_cnt[s] + 1 : 3;
                  m_tgt[s] <= br_target_i;
               end else begin
                  m_cnt[s] <= (m_cnt[s] > 0) ? m_cnt[s] - 1 : 0;
               end
            end else if (br_taken_i) begin
               m_valid[s] <= 1'b1; m_tag[s] <= tagof(br_pc_i);
               m_tgt[s] <= br_target_i; m_cnt[s] <= 2;
            end
         end
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk_i) begin
      chk("cyc_pc_next", pc_next_o, exp_next());
      chk("cyc_pred", pred_taken_o, exp_pt());
      chk("cyc_mp", mispredict_o, exp_mp());
      chk("cyc_flush", flush_o, exp_mp() || jump_valid_i);
      chk("cyc_br_cnt", br_count_o, m_br[CNT_W-1:0]);
      chk("cyc_miss_cnt", miss_count_o, m_miss[CNT_W-1:0]);
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle(input logic [31:0] pc);
      pc_i = pc; jump_valid_i = 0; br_valid_i = 0; br_taken_i = 0;
      br_pc_i = 0; br_target_i = 0; br_pred_pc_i = 0; jump_target_i = 0;
   endtask

   task automatic br(input logic [31:0] pc, input logic [31:0] bpc, input logic tk,
                     input logic [31:0] tgt, input logic [31:0] ppc);
      idle(pc);
      br_valid_i = 1; br_pc_i = bpc; br_taken_i = tk; br_target_i = tgt; br_pred_pc_i = ppc;
   endtask

   task automatic lit(input string name, input logic [31:0] nxt, input logic pt,
                      input logic fl, input logic mp);
      #1;
      chk({name, "_next"}, pc_next_o, nxt);
      chk({name, "_pred"}, pred_taken_o, pt);
      chk({name, "_flush"}, flush_o, fl);
      chk({name, "_mp"}, mispredict_o, mp);
   endtask

   task automatic cnts(input string name, input int b, input int m);
      chk({name, "_br"}, br_count_o, b);
      chk({name, "_miss"}, miss_count_o, m);
   endtask

   initial begin
      idle(32'h10);
      tick(); tick();
      rst_n_i = 1'b1;
      idle(32'h10);                      lit("rst_seq", 32'h14, 0, 0, 0); cnts("rst", 0, 0); tick();
      br(32'h10, 32'h20, 1, 32'h100, 32'h24); lit("alloc", 32'h100, 0, 1, 1); tick();
      idle(32'h20);                      lit("hit_taken", 32'h100, 1, 0, 0); cnts("after1", 1, 1); tick();
      br(32'h10, 32'h20, 0, 0, 32'h100); lit("nt1", 32'h24, 0, 1, 1); tick();
      idle(32'h20);                      lit("weak_nt", 32'h24, 0, 0, 0); cnts("after2", 2, 2); tick();
      br(32'h20, 32'h20, 0, 0, 32'h24);  lit("nt2", 32'h24, 0, 0, 0); tick();
      br(32'h20, 32'h20, 0, 0, 32'h24);  lit("nt3", 32'h24, 0, 0, 0); tick();
      // From the floor, one taken reaches 01 only: still predicts not-taken.
      br(32'h10, 32'h20, 1, 32'h100, 32'h24); lit("tk_from0", 32'h100, 0, 1, 1); tick();
      idle(32'h20);                      lit("floor", 32'h24, 0, 0, 0); cnts("after5", 5, 3); tick();
      br(32'h10, 32'h1FC, 0, 0, 32'h300);
      jump_valid_i = 1; jump_target_i = 32'h400;
                                         lit("jmp_mp", 32'h200, 0, 1, 1); tick();
      idle(32'h10); jump_valid_i = 1; jump_target_i = 32'h400;
                                         lit("jmp", 32'h400, 0, 1, 0); tick();
      idle(32'h10);                      cnts("after_jmp", 6, 4); tick();
      br(32'h20, 32'h20, 1, 32'h100, 32'h100); lit("retrain", 32'h24, 0, 0, 0); tick();
      idle(32'h20);                      lit("strong", 32'h100, 1, 0, 0); tick();
      br(32'h40, 32'h40, 1, 32'h300, 32'h300); lit("alias_rbw", 32'h44, 0, 0, 0); tick();
      idle(32'h20);                      lit("evicted", 32'h24, 0, 0, 0); tick();
      idle(32'h40);                      lit("alias_hit", 32'h300, 1, 0, 0); cnts("after_alias", 8, 4); tick();
      start_i = 0;
      br(32'h10, 32'h60, 1, 32'h500, 32'h64); lit("frozen_mp", 32'h500, 0, 1, 1); tick();
      start_i = 1;
      idle(32'h60);                      lit("frozen_btb", 32'h64, 0, 0, 0); cnts("frozen", 8, 4); tick();
      idle(32'h40);                      lit("kept", 32'h300, 1, 0, 0); tick();
      idle(32'hFFFF_FFFC);               lit("wrap", 32'h0, 0, 0, 0); tick();
      idle(32'h40);
      rst_n_i = 1'b0;
      #1;
      cnts("async_rst", 0, 0);
      chk("async_rst_pred", pred_taken_o, 0);
      chk("async_rst_next", pc_next_o, 32'h44);
      tick();
      rst_n_i = 1'b1;
      br(32'h10, 32'h8, 1, 32'h80, 32'h0C); lit("re_alloc", 32'h80, 0, 1, 1); tick();
      br(32'h8, 32'h8, 1, 32'h90, 32'h80);  lit("retarget", 32'h90, 1, 1, 1); tick();
      idle(32'h8);                      lit("new_tgt", 32'h90, 1, 0, 0); cnts("final", 2, 2); tick();
      idle(32'h10);
      tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: bench did not finish, got running expected done");
      $fatal(1);
   end
endmodule

// File: doc/next_pc_unit.md
Name: next_pc_unit

Overview:
Next-PC generator that sits directly upstream of the PC register and drives its pc_i input every cycle. It predicts the fetch successor of the current PC using a small direct-mapped branch target buffer (BTB) with 2-bit saturating counters. It applies redirects from jumps and resolved branches, raises flush on redirect, and keeps branch/mispredict statistics.

Parameters:
IDX_W, 3, BTB index width; entries = 2**IDX_W
CNT_W, 32, width of statistics counters

Ports:
clk_i  input  1  clock
rst_n_i  input  1  asynchronous active-low reset
start_i  input  1  CPU run enable; 0 freezes BTB and statistics
pc_i  input  32  current PC (output of PC register)
pc_next_o  output  32  next PC; feeds PC register pc_i
pred_taken_o  output  1  current PC predicted taken (BTB hit, counter[1]=1)
jump_valid_i  input  1  jump decoded in ID
jump_target_i  input  32  jump target
br_valid_i  input  1  branch resolved this cycle
br_pc_i  input  32  PC of resolved branch
br_taken_i  input  1  actual branch outcome
br_target_i  input  32  actual branch target
br_pred_pc_i  input  32  next PC that was predicted for this branch (carried down the pipeline)
flush_o  output  1  squash younger instructions (mispredict or jump)
mispredict_o  output  1  resolved branch was mispredicted
br_count_o  output  CNT_W  number of resolved branches
miss_count_o  output  CNT_W  number of mispredicts

Behaviour:
- Reset (async, rst_n_i=0): all BTB valid=0, tags/targets=0, counters=2'b01; br_count_o=miss_count_o=0. Combinational outputs follow their inputs, with an empty BTB.
- Lookup (combinational): idx=pc_i[IDX_W+1:2]; tag=pc_i[31:IDX_W+2]. hit = valid[idx] & tag match. pred_taken_o = hit & cnt[idx][1]. Predicted PC = pred_taken_o ? target[idx] : pc_i+4 (32-bit wrap, carry dropped).
- Resolve (combinational): correct_pc = br_taken_i ? br_target_i : br_pc_i+4. mispredict_o = br_valid_i & (correct_pc != br_pred_pc_i).
- pc_next_o priority: mispredict_o → correct_pc; else jump_valid_i → jump_target_i; else the predicted PC.
- flush_o = mispredict_o | jump_valid_i.
- BTB update at posedge clk_i, only when start_i=1 and br_valid_i=1, with index and tag taken from br_pc_i:
  - Entry hit, taken: cnt = min(cnt+1, 3); target <= br_target_i.
  - Entry hit, not taken: cnt = max(cnt-1, 0); target unchanged.
  - Miss, taken: allocate. Set valid=1, tag, target=br_target_i, cnt=2'b10. This overwrites any conflicting entry.
  - Miss, not taken: no change.
- Read-before-write: when a lookup and an update hit the same index in one cycle, the lookup uses the pre-edge contents.
- Statistics at posedge when start_i=1: br_count_o += br_valid_i; miss_count_o += mispredict_o. Both saturate at all-ones and do not wrap.
- start_i=0: no BTB or statistics change. Combinational outputs still valid; the PC register ignores them.
- Reset mid-operation: state clears immediately, regardless of clk_i. No pending updates survive.
- Pipeline stalls are not visible here: the PC register holds via its own write enable. A resolve may occur during a stall and is applied normally.

Test Plan:
- Reset, then pc_i=0x0000_0010, no events → pc_next_o=0x14, pred_taken_o=0, flush_o=0, counters 0.
- Branch at pc 0x20 resolved taken to 0x100 with br_pred_pc_i=0x24 → mispredict_o=1, flush_o=1, pc_next_o=0x100. Next cycle: pc_i=0x20 gives pred_taken_o=1, pc_next_o=0x100. br_count_o=1, miss_count_o=1.
- Same branch resolved not-taken twice (br_pred_pc_i=0x100): first resolve → mispredict, counter 10→01. pc_i=0x20 then predicts 0x24. Second not-taken, br_pred_pc_i=0x24 → no mispredict, counter 01→00 and stays 00 on a third not-taken.
- Jump and mispredict in the same cycle (jump_target_i=0x400, correct_pc=0x200) → pc_next_o=0x200, flush_o=1. Jump alone → pc_next_o=0x400, no BTB/statistics change.
- Aliasing: 0x20 and 0x40 share an index (IDX_W=3). Taken 0x40→0x300 replaces the 0x20 entry, and pc_i=0x20 then predicts 0x24. Lookup of pc_i=0x40 in the same cycle as its allocation returns 0x44.
- start_i=0 with br_valid_i=1 taken → no BTB or counter change. Assert rst_n_i mid-run with no clock edge → counters read 0 and BTB misses immediately.
